// File: rtl/gpr_wb_arbiter.sv
// Two-requester GPR writeback arbiter: per-requester FIFOs, round-robin drain into a
// registered single write port, plus a pending-write scoreboard for decode hazards.
module gpr_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              gpr_we_,
    output logic [ADDR_W-1:0] gpr_wr_addr,
    output logic [DATA_W-1:0] gpr_wr_data,
    input  logic [ADDR_W-1:0] chk_addr_0,
    input  logic [ADDR_W-1:0] chk_addr_1,
    output logic              chk_hazard_0,
    output logic              chk_hazard_1,
    output logic              idle
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_addr [2];
    logic [DATA_W-1:0] in_data [2];
    logic [ADDR_W-1:0] chk_addr [2];

    logic [ADDR_W-1:0] q_addr [2][FIFO_DEPTH];
    logic [DATA_W-1:0] q_data [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [2];
    logic [PTR_W-1:0]  rd_ptr [2];
    logic [CNT_W-1:0]  count  [2];
    logic              rr_pri1;

    logic [1:0] ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] not_empty;
    logic [1:0] hazard;
    logic [FIFO_DEPTH-1:0] slot_valid [2];
    logic [PTR_W-1:0] off;

    assign in_valid    = {req1_valid, req0_valid};
    assign in_addr[0]  = req0_addr;
    assign in_addr[1]  = req1_addr;
    assign in_data[0]  = req0_data;
    assign in_data[1]  = req1_data;
    assign chk_addr[0] = chk_addr_0;
    assign chk_addr[1] = chk_addr_1;

    // Writes to r0 complete the handshake but never occupy a FIFO slot.
    always_comb begin
        not_empty = '0;
        ready     = '0;
        push      = '0;
        pop       = '0;
        for (int s = 0; s < 2; s++) begin
            not_empty[s] = (count[s] != '0);
            ready[s]     = ~reset & (count[s] != FULL);
            push[s]      = in_valid[s] & ready[s] & (in_addr[s] != '0);
        end
        pop[0] = not_empty[0] & (~not_empty[1] | ~rr_pri1);
        pop[1] = not_empty[1] & (~not_empty[0] | rr_pri1);
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                q_addr[s][wr_ptr[s]] <= in_addr[s];
                q_data[s][wr_ptr[s]] <= in_data[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
            rr_pri1     <= 1'b0;
            gpr_we_     <= 1'b1;
            gpr_wr_addr <= '0;
            gpr_wr_data <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
            if (pop[0]) begin
                gpr_we_     <= 1'b0;
                gpr_wr_addr <= q_addr[0][rd_ptr[0]];
                gpr_wr_data <= q_data[0][rd_ptr[0]];
            end else if (pop[1]) begin
                gpr_we_     <= 1'b0;
                gpr_wr_addr <= q_addr[1][rd_ptr[1]];
                gpr_wr_data <= q_data[1][rd_ptr[1]];
            end else begin
                gpr_we_ <= 1'b1;
            end
            // Priority only flips when both sides actually competed.
            if (&not_empty) rr_pri1 <= ~rr_pri1;
        end
    end

    always_comb begin
        off    = '0;
        hazard = '0;
        for (int s = 0; s < 2; s++) begin
            slot_valid[s] = '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                off              = PTR_W'(i) - rd_ptr[s];
                slot_valid[s][i] = ({1'b0, off} < count[s]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (chk_addr[k] != '0) begin
                for (int s = 0; s < 2; s++) begin
                    for (int i = 0; i < FIFO_DEPTH; i++) begin
                        if (slot_valid[s][i] && (q_addr[s][i] == chk_addr[k])) hazard[k] = 1'b1;
                    end
                end
                if (!gpr_we_ && (gpr_wr_addr == chk_addr[k])) hazard[k] = 1'b1;
            end
        end
    end

    assign chk_hazard_0 = hazard[0];
    assign chk_hazard_1 = hazard[1];
    assign req0_ready   = ready[0];
    assign req1_ready   = ready[1];
    assign idle         = (count[0] == '0) & (count[1] == '0) & gpr_we_;

endmodule
